// File: rtl/sccb_reg_writer.sv
`default_nettype none
// ============================================================================
// Module      : sccb_reg_writer
// Description : SCCB (I2C-compatible) 3-phase write master for OV7675
//               register programming. Runs on clk_100; SCL timing comes from
//               an internal quarter-bit tick divider.
// Ports       : clk_100     - system clock
//               rst         - asynchronous active-high reset
//               i_addr_data - [15:8] register address, [7:0] register data
//               i_strobe    - write request, sampled only while o_ready=1
//               o_ready     - idle, able to accept a strobe
//               o_done      - one-cycle pulse at end of transaction
//               o_nack      - an ACK slot of the last transaction read high
//               io_sda      - open-drain SDA (driven 0 or Z)
//               io_scl      - open-drain SCL (driven 0 or Z)
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_reg_writer #(
  parameter int         CLK_DIV  = 250,
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic [15:0] i_addr_data,
  input  logic        i_strobe,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_nack,
  inout  wire         io_sda,
  inout  wire         io_scl
);

  localparam int c_tick_w = ($clog2(CLK_DIV) < 1) ? 1 : $clog2(CLK_DIV);
  localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(CLK_DIV - 1);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_start   = 3'd1;
  localparam logic [2:0] c_bits    = 3'd2;
  localparam logic [2:0] c_stop    = 3'd3;
  localparam logic [2:0] c_busfree = 3'd4;

  localparam logic [4:0] c_last_slot = 5'd26;

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic [c_tick_w-1:0] r_tick_cnt;
  logic [1:0]          r_quarter;
  logic [4:0]          r_slot;
  logic [15:0]         r_addr_data;
  logic                r_done;
  logic                r_nack;

  logic                w_accept;
  logic                w_tick;
  logic                w_last_q;
  logic [26:0]         w_frame;
  logic [4:0]          w_bit_idx;
  logic                w_ack_slot;
  logic                w_scl_low;
  logic                w_sda_low;

  assign w_accept = (r_state == c_idle) && i_strobe;
  assign w_tick   = (r_state != c_idle) && (r_tick_cnt == c_tick_max);
  assign w_last_q = w_tick && (r_quarter == 2'd3);

  // Whole serial frame, first bit in [26]. ACK positions hold 1 so the
  // master simply releases SDA there.
  assign w_frame    = {DEV_ADDR, 1'b0, 1'b1, r_addr_data[15:8], 1'b1,
                       r_addr_data[7:0], 1'b1};
  assign w_bit_idx  = c_last_slot - r_slot;
  assign w_ack_slot = (r_slot == 5'd8) || (r_slot == 5'd17) || (r_slot == 5'd26);

  // State register
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:    if (i_strobe) w_next_state = c_start;
      c_start:   if (w_last_q) w_next_state = c_bits;
      c_bits:    if (w_last_q && (r_slot == c_last_slot)) w_next_state = c_stop;
      c_stop:    if (w_last_q) w_next_state = c_busfree;
      c_busfree: if (w_last_q) w_next_state = c_idle;
      default:   w_next_state = c_idle;
    endcase
  end

  // Output logic: line drives are decoded from state and quarter only
  always_comb begin
    w_scl_low = 1'b0;
    w_sda_low = 1'b0;
    o_ready   = (r_state == c_idle);
    case (r_state)
      c_start: begin
        w_scl_low = (r_quarter == 2'd3);
        w_sda_low = (r_quarter != 2'd0);
      end
      c_bits: begin
        w_scl_low = (r_quarter == 2'd0) || (r_quarter == 2'd3);
        w_sda_low = ~w_frame[w_bit_idx];
      end
      c_stop: begin
        w_scl_low = (r_quarter == 2'd0);
        w_sda_low = (r_quarter <= 2'd1);
      end
      default: begin
        w_scl_low = 1'b0;
        w_sda_low = 1'b0;
      end
    endcase
  end

  assign io_scl = w_scl_low ? 1'b0 : 1'bz;
  assign io_sda = w_sda_low ? 1'b0 : 1'bz;
  assign o_done = r_done;
  assign o_nack = r_nack;

  // Tick divider, quarter/slot counters, request latch and status flags
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_tick_cnt  <= '0;
      r_quarter   <= 2'd0;
      r_slot      <= 5'd0;
      r_addr_data <= 16'h0000;
      r_done      <= 1'b0;
      r_nack      <= 1'b0;
    end else begin
      r_done <= (r_state == c_busfree) && w_last_q;
      if (w_accept) begin
        r_addr_data <= i_addr_data;
        r_nack      <= 1'b0;
        r_tick_cnt  <= '0;
        r_quarter   <= 2'd0;
        r_slot      <= 5'd0;
      end else if (r_state != c_idle) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        if (w_tick) begin
          r_quarter <= r_quarter + 2'd1;
        end
        if ((r_state == c_bits) && w_last_q) begin
          r_slot <= r_slot + 5'd1;
        end
        // ACK is sampled on the tick that ends q1, mid SCL-high
        if ((r_state == c_bits) && w_ack_slot && w_tick &&
            (r_quarter == 2'd1) && io_sda) begin
          r_nack <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sccb_reg_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sccb_reg_writer
// Description : Directed self-checking bench for sccb_reg_writer with a bus
//               monitor / ACKing slave model on pulled-up SDA and SCL.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_reg_writer;

  localparam int CLK_DIV    = 2;
  localparam int T_CLK      = 10;
  localparam int T_HALF_BIT = 2 * CLK_DIV * T_CLK;
  localparam int LAT        = 120 * CLK_DIV;

  logic        clk_100     = 1'b0;
  logic        rst         = 1'b1;
  logic [15:0] i_addr_data = 16'h0000;
  logic        i_strobe    = 1'b0;
  logic        o_ready;
  logic        o_done;
  logic        o_nack;
  wire         sda;
  wire         scl;

  pullup (sda);
  pullup (scl);

  logic slave_low = 1'b0;
  logic ack_en    = 1'b1;
  assign sda = slave_low ? 1'b0 : 1'bz;

  int checks = 0;
  int errors = 0;

  always #(T_CLK / 2) clk_100 = ~clk_100;

  sccb_reg_writer #(
    .CLK_DIV  (CLK_DIV),
    .DEV_ADDR (7'h21)
  ) dut (
    .clk_100     (clk_100),
    .rst         (rst),
    .i_addr_data (i_addr_data),
    .i_strobe    (i_strobe),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_nack      (o_nack),
    .io_sda      (sda),
    .io_scl      (scl)
  );

  // ---------------------------------------------------------------- monitor
  logic        p_sda = 1'b1;
  logic        p_scl = 1'b1;
  bit          in_tx = 1'b0;
  bit          pos_valid = 1'b0;
  bit          neg_valid = 1'b0;
  int          mon_bits = 0;
  int          mon_starts = 0;
  int          mon_stops = 0;
  int          mon_viol = 0;
  logic [27:0] mon_shift = '0;
  logic [26:0] mon_q[$];
  time         t_pos = 0;
  time         t_neg = 0;
  time         t_start = 0;
  time         t_stop = 0;

  always @(sda or scl) begin
    if (scl === 1'b1 && p_scl === 1'b1 && sda !== p_sda) begin
      if (sda === 1'b0) begin
        if (in_tx) mon_viol++;
        in_tx = 1'b1; mon_bits = 0; mon_shift = '0;
        pos_valid = 1'b0; neg_valid = 1'b0; slave_low = 1'b0;
        mon_starts++; t_start = $time;
      end else begin
        // 27 frame bits plus the SCL rise inside STOP
        if (!in_tx || mon_bits != 28) mon_viol++;
        else mon_q.push_back(mon_shift[27:1]);
        in_tx = 1'b0; pos_valid = 1'b0; neg_valid = 1'b0; slave_low = 1'b0;
        mon_stops++; t_stop = $time;
      end
    end else if (scl === 1'b1 && p_scl !== 1'b1) begin
      if (in_tx) begin
        if (neg_valid && ($time - t_neg) != T_HALF_BIT) mon_viol++;
        mon_bits++;
        mon_shift = {mon_shift[26:0], (sda === 1'b1)};
        pos_valid = 1'b1; t_pos = $time;
      end
    end else if (scl !== 1'b1 && p_scl === 1'b1) begin
      if (in_tx) begin
        if (pos_valid && ($time - t_pos) != T_HALF_BIT) mon_viol++;
        neg_valid = 1'b1; t_neg = $time;
        slave_low = ack_en && (mon_bits != 0) && (mon_bits % 9 == 8);
      end
    end
    p_sda = sda;
    p_scl = scl;
  end

  function automatic logic [26:0] exp_frame(input logic [15:0] ad, input logic ack);
    logic a;
    a = ~ack;
    return {8'h42, a, ad[15:8], a, ad[7:0], a};
  endfunction

  function automatic logic [26:0] pop_frame();
    if (mon_q.size() == 0) return 'x;
    return mon_q.pop_front();
  endfunction

  // Issue one write from a point just after a clock edge; returns cycles
  // from the accepting edge to o_done (0 on timeout).
  task automatic do_write(input logic [15:0] ad, output int cyc,
                          output logic rdy_before, output logic nack_after_acc,
                          output logic rdy_at_done);
    rdy_before  = o_ready;
    i_addr_data = ad;
    i_strobe    = 1'b1;
    @(posedge clk_100); #1;
    i_strobe       = 1'b0;
    nack_after_acc = o_nack;
    cyc            = 0;
    rdy_at_done    = 1'b0;
    for (int n = 1; n <= LAT + 50; n++) begin
      @(posedge clk_100); #1;
      if (o_done === 1'b1) begin
        cyc         = n;
        rdy_at_done = o_ready;
        break;
      end
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    repeat (3) @(posedge clk_100);
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
    checks++; if (o_nack !== 1'b0) begin errors++; $display("FAIL reset_nack: got %b want 0", o_nack); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b want 1", scl); end
    @(negedge clk_100); rst = 1'b0;
    @(posedge clk_100); #1;
  endtask

  task automatic test_write_ack();
    int cyc; logic rb, na, rd; logic [26:0] f;
    ack_en = 1'b1; mon_q.delete();
    do_write(16'h1280, cyc, rb, na, rd);
    f = pop_frame();
    checks++; if (rb !== 1'b1) begin errors++; $display("FAIL ack_ready_before: got %b want 1", rb); end
    checks++; if (cyc != LAT) begin errors++; $display("FAIL ack_latency: got %0d want %0d", cyc, LAT); end
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL ack_ready_at_done: got %b want 1", rd); end
    checks++; if (o_nack !== 1'b0) begin errors++; $display("FAIL ack_nack: got %b want 0", o_nack); end
    checks++; if (f !== exp_frame(16'h1280, 1'b1)) begin errors++; $display("FAIL ack_frame: got %h want %h", f, exp_frame(16'h1280, 1'b1)); end
  endtask

  task automatic test_nack();
    int cyc; logic rb, na, rd; logic [26:0] f;
    ack_en = 1'b0; mon_q.delete();
    do_write(16'h3A04, cyc, rb, na, rd);
    f = pop_frame();
    checks++; if (cyc != LAT) begin errors++; $display("FAIL nack_latency: got %0d want %0d", cyc, LAT); end
    checks++; if (o_nack !== 1'b1) begin errors++; $display("FAIL nack_flag: got %b want 1", o_nack); end
    checks++; if (f !== exp_frame(16'h3A04, 1'b0)) begin errors++; $display("FAIL nack_frame: got %h want %h", f, exp_frame(16'h3A04, 1'b0)); end
    ack_en = 1'b1;
    do_write(16'h2233, cyc, rb, na, rd);
    f = pop_frame();
    checks++; if (na !== 1'b0) begin errors++; $display("FAIL nack_cleared_on_accept: got %b want 0", na); end
    checks++; if (o_nack !== 1'b0) begin errors++; $display("FAIL nack_after_ack_write: got %b want 0", o_nack); end
    checks++; if (f !== exp_frame(16'h2233, 1'b1)) begin errors++; $display("FAIL nack_next_frame: got %h want %h", f, exp_frame(16'h2233, 1'b1)); end
  endtask

  task automatic test_ignore_busy();
    int dones; int first; logic [26:0] f;
    ack_en = 1'b1; mon_q.delete();
    i_addr_data = 16'h5A3C; i_strobe = 1'b1;
    @(posedge clk_100); #1;
    i_strobe = 1'b0;
    dones = 0; first = 0;
    for (int n = 1; n <= LAT + 60; n++) begin
      if (n == 10) begin i_addr_data = 16'hC3E7; i_strobe = 1'b1; end
      if (n == 11) i_strobe = 1'b0;
      @(posedge clk_100); #1;
      if (o_done === 1'b1) begin
        dones++;
        if (first == 0) first = n;
      end
    end
    f = pop_frame();
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    checks++; if (first != LAT) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", first, LAT); end
    checks++; if (f !== exp_frame(16'h5A3C, 1'b1)) begin errors++; $display("FAIL ignore_frame: got %h want %h", f, exp_frame(16'h5A3C, 1'b1)); end
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL ignore_extra_frames: got %0d want 0", mon_q.size()); end
  endtask

  task automatic test_back_to_back();
    int c1, c2; logic rb, na, rd; time stop1, gap; logic [26:0] f1, f2;
    ack_en = 1'b1; mon_q.delete();
    do_write(16'h1180, c1, rb, na, rd);
    stop1 = t_stop;
    do_write(16'h1214, c2, rb, na, rd);
    gap = t_start - stop1;
    f1 = pop_frame();
    f2 = pop_frame();
    checks++; if (c1 != LAT) begin errors++; $display("FAIL b2b_latency1: got %0d want %0d", c1, LAT); end
    checks++; if (rb !== 1'b1) begin errors++; $display("FAIL b2b_ready_second: got %b want 1", rb); end
    checks++; if (c2 != LAT) begin errors++; $display("FAIL b2b_latency2: got %0d want %0d", c2, LAT); end
    // STOP q2..q3 + BUSFREE (6 ticks), the accept cycle, START q0 (1 tick)
    checks++; if (gap != time'(15 * T_CLK)) begin errors++; $display("FAIL b2b_gap: got %0t want %0d", gap, 15 * T_CLK); end
    checks++; if (f1 !== exp_frame(16'h1180, 1'b1)) begin errors++; $display("FAIL b2b_frame1: got %h want %h", f1, exp_frame(16'h1180, 1'b1)); end
    checks++; if (f2 !== exp_frame(16'h1214, 1'b1)) begin errors++; $display("FAIL b2b_frame2: got %h want %h", f2, exp_frame(16'h1214, 1'b1)); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic rb, na, rd; logic [26:0] f;
    ack_en = 1'b1;
    i_addr_data = 16'h4D5E; i_strobe = 1'b1;
    @(posedge clk_100); #1;
    i_strobe = 1'b0;
    repeat (60) @(posedge clk_100);
    #1 rst = 1'b1;
    #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rstmid_sda: got %b want 1", sda); end
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL rstmid_scl: got %b want 1", scl); end
    @(negedge clk_100); rst = 1'b0;
    @(posedge clk_100); #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", o_ready); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", o_done); end
    mon_q.delete();
    do_write(16'h6B2C, cyc, rb, na, rd);
    f = pop_frame();
    checks++; if (cyc != LAT) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", cyc, LAT); end
    checks++; if (f !== exp_frame(16'h6B2C, 1'b1)) begin errors++; $display("FAIL rstmid_frame: got %h want %h", f, exp_frame(16'h6B2C, 1'b1)); end
  endtask

  task automatic test_protocol_burst();
    int cyc; logic rb, na, rd; logic [15:0] d; logic [26:0] f;
    int v0, s0, p0;
    ack_en = 1'b1; mon_q.delete();
    v0 = mon_viol; s0 = mon_starts; p0 = mon_stops;
    for (int i = 0; i < 198; i++) begin
      d = 16'($urandom);
      do_write(d, cyc, rb, na, rd);
      f = pop_frame();
      checks++; if (cyc != LAT) begin errors++; $display("FAIL burst_latency[%0d]: got %0d want %0d", i, cyc, LAT); end
      checks++; if (f !== exp_frame(d, 1'b1)) begin errors++; $display("FAIL burst_frame[%0d]: got %h want %h", i, f, exp_frame(d, 1'b1)); end
    end
    checks++; if (mon_viol - v0 != 0) begin errors++; $display("FAIL burst_protocol_violations: got %0d want 0", mon_viol - v0); end
    checks++; if (mon_starts - s0 != 198) begin errors++; $display("FAIL burst_starts: got %0d want 198", mon_starts - s0); end
    checks++; if (mon_stops - p0 != 198) begin errors++; $display("FAIL burst_stops: got %0d want 198", mon_stops - p0); end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_nack();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_protocol_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sccb_reg_writer.md
Name: sccb_reg_writer

Overview:
- Single-clock SCCB (I2C-compatible) 3-phase write master that programs OV7675 registers.
- Sits directly upstream of the camera's SCCB pins. The camera init sequencer presents one {reg_addr, reg_data} pair per strobe and waits for o_ready before sending the next.
- Replaces the xclk-clocked config master: it runs entirely on clk_100, and SCL timing comes from an internal tick divider.

Parameters:
- CLK_DIV, 250: clk_100 cycles per quarter-bit tick (250 → 100 kHz SCL); legal range 2..65535.
- DEV_ADDR, 7'h21: 7-bit SCCB slave ID; the write ID byte is {DEV_ADDR, 1'b0} = 8'h42.

Ports:
- clk_100, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- i_addr_data, input, 16: [15:8] register address, [7:0] register data.
- i_strobe, input, 1: request a write; sampled only while o_ready=1.
- o_ready, output, 1: idle and able to accept a strobe.
- o_done, output, 1: one-cycle pulse when a transaction ends.
- o_nack, output, 1: at least one ACK slot of the last transaction read SDA high; valid from o_done until the next accept.
- io_sda, inout, 1: open-drain SDA; driven 0 or Z only.
- io_scl, inout, 1: open-drain SCL; driven 0 or Z only.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - o_ready=1, o_done=0, o_nack=0.
  - SDA and SCL released (Z); tick counter=0; state=IDLE.
  - Reset mid-transaction aborts immediately, releasing both lines. No STOP is generated.
- Accept:
  - i_strobe=1 with o_ready=1 at a clk_100 edge latches i_addr_data, clears o_nack and the tick counter, and enters START.
  - o_ready is 0 from the next cycle.
  - i_strobe while o_ready=0 is ignored; it is not queued.
- Tick:
  - An internal counter counts 0..CLK_DIV-1.
  - A tick occurs when it wraps; each phase step advances on a tick.
- States: IDLE → START → BITS → STOP → BUSFREE → IDLE.
- START (4 ticks), as (q0, q1, q2, q3):
  - SCL: Z, Z, Z, 0.
  - SDA: Z, 0, 0, 0.
- BITS: 27 bit slots of 4 ticks each.
  - Slot order: ID byte, ACK, reg_addr byte, ACK, reg_data byte, ACK. Data bits go MSB first.
  - Per slot q0..q3, SCL: 0, Z, Z, 0.
  - Data slot: SDA=0 if bit=0, else Z, set at q0 and held through q3.
  - ACK slot: SDA released (Z). The line is sampled on the tick ending q1. A high sample (bus value 1) sets o_nack.
  - The transaction continues regardless of NACK (SCCB don't-care bit).
- STOP (4 ticks), as (q0, q1, q2, q3):
  - SCL: 0, Z, Z, Z.
  - SDA: 0, 0, Z, Z.
- BUSFREE: 4 ticks with both lines released.
  - On its last tick, o_done pulses for 1 cycle and o_ready returns to 1 in the same cycle.
- Latency:
  - Exactly 120 × CLK_DIV cycles from the accepting edge to the o_done/o_ready edge (4+108+4+4 ticks).
  - A new strobe is accepted on the o_ready=1 cycle itself, so back-to-back writes are allowed.
- Line rules:
  - SDA changes only while SCL is held low, except in START and STOP.
  - The block never drives 1. io_* are read through input buffers for ACK sampling; the bench provides pullups.
- Width rules: the tick counter is $clog2(CLK_DIV) bits, minimum 1. The slot counter is 5 bits (0..26). The quarter counter is 2 bits.

Test Plan:
- Reset, then CLK_DIV=2, strobe 16'h1280, slave ACKs all → SDA/SCL decode gives START, 0x42, A, 0x12, A, 0x80, A, STOP. o_done at exactly cycle 240 after accept; o_nack=0.
- No slave (SDA pulled high) on strobe 16'h3A04 → full transaction still completes in 240 cycles; o_nack=1 after o_done. Next strobe clears o_nack on accept.
- Second strobe issued 10 cycles into a transaction with different data → ignored. Bus shows only the first write; exactly one o_done.
- Strobe asserted in the same cycle o_ready returns, for 16'h1180 then 16'h1214 → two complete transactions; the second START begins with no idle gap beyond BUSFREE.
- rst asserted at cycle 60 of a transaction → SDA and SCL read Z (1 via pullup) within the same cycle; o_ready=1 and o_done=0 after release. A fresh strobe yields a correct full write.
- Protocol checker over a 198-write random-data burst → no SDA transition while SCL high, except START and STOP; SCL high and low periods each equal 2 × CLK_DIV cycles.
